load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_if.sv | 47 ++++
 rtl/load_store_unit.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - request, memory and writeback channels of the load/store unit
// LSU_UPDATE_EN adds the update-form request fields upd and ra.
interface load_store_unit_if #(
    parameter int N      = 32,
    parameter int ADDR_W = 7
);
    logic                req_valid;
    logic                req_ready;
    logic [2:0]          op;
    logic [N-1:0]        base;
    logic [15:0]         disp;
    logic [4:0]          rt;
    logic [N-1:0]        store_data;
`ifdef LSU_UPDATE_EN
    logic                upd;
    logic [4:0]          ra;
`endif
    logic [ADDR_W-1:0]   mem_addr;
    logic [N-1:0]        mem_wdata;
    logic [N/8-1:0]      mem_be;
    logic                mem_re;
    logic                mem_we;
    logic [N-1:0]        mem_rdata;
    logic                mem_ack;
    logic                wb_valid;
    logic [4:0]          wb_reg;
    logic [N-1:0]        wb_data;
    logic                err;

    modport slave (
        input  req_valid, op, base, disp, rt, store_data, mem_rdata, mem_ack,
`ifdef LSU_UPDATE_EN
        input  upd, ra,
`endif
        output req_ready, mem_addr, mem_wdata, mem_be, mem_re, mem_we,
        output wb_valid, wb_reg, wb_data, err
    );

    modport master (
        output req_valid, op, base, disp, rt, store_data, mem_rdata, mem_ack,
`ifdef LSU_UPDATE_EN
        output upd, ra,
`endif
        input  req_ready, mem_addr, mem_wdata, mem_be, mem_re, mem_we,
        input  wb_valid, wb_reg, wb_data, err
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store unit with lane steering
// Optional update-form addressing (RA <- EA) is enabled by macro LSU_UPDATE_EN.
module load_store_unit #(
    parameter int N      = 32,
    parameter int ADDR_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    load_store_unit_if.slave bus
);
    localparam int NB = N / 8;
    localparam int LB = $clog2(NB);

    typedef enum logic [2:0] {
        IDLE, EA, MEM, WB
`ifdef LSU_UPDATE_EN
        , UPD
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [N-1:0]      base_q, base_d, sd_q, sd_d, ea_q, ea_d;
    logic [15:0]       disp_q, disp_d;
    logic [4:0]        rt_q, rt_d, wb_reg_q, wb_reg_d;
    logic              req_ready_q, req_ready_d, mem_re_q, mem_re_d, mem_we_q, mem_we_d;
    logic              wb_valid_q, wb_valid_d, err_q, err_d;
    logic [NB-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [N-1:0]      mem_wdata_q, mem_wdata_d, wb_data_q, wb_data_d;
`ifdef LSU_UPDATE_EN
    logic              upd_q, upd_d;
    logic [4:0]        ra_q, ra_d;
`else
    logic              unused_ea;
    assign unused_ea = ^ea_q;
`endif

    logic [N-1:0]      ea_c, shifted, ld_val;
    logic [LB-1:0]     k_c;
    logic              is_store, sz_byte, sz_word, sz_half, bad;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        base_d      = base_q;
        disp_d      = disp_q;
        rt_d        = rt_q;
        sd_d        = sd_q;
        ea_d        = ea_q;
        req_ready_d = req_ready_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wb_valid_d  = 1'b0;
        wb_reg_d    = wb_reg_q;
        wb_data_d   = wb_data_q;
        err_d       = 1'b0;
`ifdef LSU_UPDATE_EN
        upd_d       = upd_q;
        ra_d        = ra_q;
`endif
        ea_c     = base_q + {{(N-16){disp_q[15]}}, disp_q};
        k_c      = ea_c[LB-1:0];
        is_store = op_q[2];
        sz_byte  = (op_q[1:0] == 2'b00);
        sz_word  = (op_q[1:0] == 2'b10);
        sz_half  = !sz_byte && !sz_word;
        bad      = (op_q == 3'b111) || (sz_half && ea_c[0]) || (sz_word && (ea_c[1:0] != 2'b00));
`ifdef LSU_UPDATE_EN
        bad      = bad || (upd_q && !is_store && (ra_q == 5'd0 || ra_q == rt_q));
`endif
        // Loads pick their lanes from the EA latched in the EA cycle.
        shifted  = bus.mem_rdata >> {ea_q[LB-1:0], 3'b000};
        ld_val   = '0;
        case (op_q[1:0])
            2'b00:   ld_val[7:0]  = shifted[7:0];
            2'b01:   ld_val[15:0] = shifted[15:0];
            2'b10:   ld_val[31:0] = shifted[31:0];
            default: begin
                ld_val       = {N{shifted[15]}};
                ld_val[15:0] = shifted[15:0];
            end
        endcase

        case (state_q)
            IDLE: if (bus.req_valid) begin
                op_d        = bus.op;
                base_d      = bus.base;
                disp_d      = bus.disp;
                rt_d        = bus.rt;
                sd_d        = bus.store_data;
`ifdef LSU_UPDATE_EN
                upd_d       = bus.upd;
                ra_d        = bus.ra;
`endif
                req_ready_d = 1'b0;
                state_d     = EA;
            end
            EA: begin
                ea_d = ea_c;
                if (bad) begin
                    err_d       = 1'b1;
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end else begin
                    mem_addr_d = ea_c[ADDR_W+LB-1:LB];
                    mem_re_d   = !is_store;
                    mem_we_d   = is_store;
                    if (sz_byte) begin
                        mem_be_d    = {{(NB-1){1'b0}}, 1'b1} << k_c;
                        mem_wdata_d = {NB{sd_q[7:0]}};
                    end else if (sz_word) begin
                        mem_be_d    = {{(NB-4){1'b0}}, 4'hF} << k_c;
                        mem_wdata_d = {(NB/4){sd_q[31:0]}};
                    end else begin
                        mem_be_d    = {{(NB-2){1'b0}}, 2'b11} << k_c;
                        mem_wdata_d = {(NB/2){sd_q[15:0]}};
                    end
                    state_d = MEM;
                end
            end
            MEM: if (bus.mem_ack) begin
                mem_re_d = 1'b0;
                mem_we_d = 1'b0;
                mem_be_d = '0;
                if (!is_store) begin
                    wb_valid_d = 1'b1;
                    wb_reg_d   = rt_q;
                    wb_data_d  = ld_val;
                    state_d    = WB;
`ifdef LSU_UPDATE_EN
                end else if (upd_q) begin
                    wb_valid_d = 1'b1;
                    wb_reg_d   = ra_q;
                    wb_data_d  = ea_q;
                    state_d    = UPD;
`endif
                end else begin
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            WB: begin
`ifdef LSU_UPDATE_EN
                if (upd_q) begin
                    wb_valid_d = 1'b1;
                    wb_reg_d   = ra_q;
                    wb_data_d  = ea_q;
                    state_d    = UPD;
                end else begin
                    req_ready_d = 1'b1;
                    state_d     = IDLE;
                end
`else
                req_ready_d = 1'b1;
                state_d     = IDLE;
`endif
            end
            default: begin
                req_ready_d = 1'b1;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            base_q      <= '0;
            disp_q      <= '0;
            rt_q        <= '0;
            sd_q        <= '0;
            ea_q        <= '0;
            req_ready_q <= 1'b1;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            wb_valid_q  <= 1'b0;
            wb_reg_q    <= '0;
            wb_data_q   <= '0;
            err_q       <= 1'b0;
`ifdef LSU_UPDATE_EN
            upd_q       <= 1'b0;
            ra_q        <= '0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            base_q      <= base_d;
            disp_q      <= disp_d;
            rt_q        <= rt_d;
            sd_q        <= sd_d;
            ea_q        <= ea_d;
            req_ready_q <= req_ready_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            wb_valid_q  <= wb_valid_d;
            wb_reg_q    <= wb_reg_d;
            wb_data_q   <= wb_data_d;
            err_q       <= err_d;
`ifdef LSU_UPDATE_EN
            upd_q       <= upd_d;
            ra_q        <= ra_d;
`endif
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_reg    = wb_reg_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.err       = err_q;
endmodule
